// File: rtl/rv_pkg.sv
// Shared types and constants for the rv boot loader and its byte packer.
package rv_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BOOT_HDR_BYTES  = 4;
    localparam int unsigned BOOT_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_t;

endpackage

// File: rtl/rv_byte_packer.sv
// Assembles four stream bytes into a little-endian word; the word is presented
// combinationally in the same cycle as its fourth byte.
module rv_byte_packer
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned SH_W = (BOOT_WORD_BYTES - 1) * BYTE_W;

    logic [1:0]      cnt;
    logic [SH_W-1:0] shreg;

    // Newest byte enters at the top so the first byte ends up in bits [7:0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 2'd0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= 2'd0;
            shreg <= '0;
        end else if (load) begin
            cnt   <= cnt + 2'd1;
            shreg <= {data, shreg[SH_W-1:BYTE_W]};
        end
    end

    assign word_valid_c = load && (cnt == 2'(BOOT_WORD_BYTES - 1));
    assign word_c       = {data, shreg};

endmodule

// File: rtl/rv_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into program memory
// and holds the rv core in reset until the image is written and verified.
module rv_boot_loader
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned BASE_WORD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    boot_state_t       state, state_n;
    logic [WORD_W-1:0] len, len_n, len_full;
    logic [1:0]        hdr_cnt, hdr_cnt_n;
    logic [WORD_W-1:0] word_idx, word_idx_n;
    logic [BYTE_W-1:0] csum, csum_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [WORD_W-1:0] mem_wdata_n;
    logic              in_ready_n, done_n, error_n, core_rst_n;
    logic              xfer;
    logic              pack_load, pack_clear;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;

    assign xfer       = in_valid && in_ready;
    assign pack_load  = xfer && (state == DATA);
    assign pack_clear = (state != DATA);

    rv_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (pack_clear),
        .load         (pack_load),
        .data         (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LEN;
            len       <= '0;
            hdr_cnt   <= 2'd0;
            word_idx  <= '0;
            csum      <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            hdr_cnt   <= hdr_cnt_n;
            word_idx  <= word_idx_n;
            csum      <= csum_n;
            in_ready  <= in_ready_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            core_rst  <= core_rst_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    // Next-state, counters, checksum and write register
    always_comb begin
        state_n     = state;
        len_n       = len;
        hdr_cnt_n   = hdr_cnt;
        word_idx_n  = word_idx;
        csum_n      = csum;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        len_full    = {in_data, len[WORD_W-1:BYTE_W]};

        case (state)
            LEN: begin
                if (xfer) begin
                    len_n     = len_full;
                    hdr_cnt_n = hdr_cnt + 2'd1;
                    if (hdr_cnt == 2'(BOOT_HDR_BYTES - 1)) begin
                        if (len_full > WORD_W'(MAX_WORDS))
                            state_n = ERR;
                        else if (len_full == '0)
                            state_n = CSUM;
                        else
                            state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    csum_n = csum ^ in_data;
                    if (word_valid_c) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = ADDR_W'(BASE_WORD) + ADDR_W'(word_idx);
                        mem_wdata_n = word_c;
                        word_idx_n  = word_idx + WORD_W'(1);
                        if (word_idx == len - WORD_W'(1))
                            state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer)
                    state_n = (in_data == csum) ? DONE : ERR;
            end
            default: begin
            end
        endcase

        in_ready_n = (state_n == LEN) || (state_n == DATA) || (state_n == CSUM);
        done_n     = (state_n == DONE);
        error_n    = (state_n == ERR);
        core_rst_n = (state_n != DONE);
    end

endmodule

// File: tb/tb_rv_boot_loader.sv
// Self-checking bench for rv_boot_loader: directed images from the bring-up
// plan plus randomized images checked against a stream-level model.
module tb_rv_boot_loader;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_WORDS = 16384;
    localparam int unsigned BASE_WORD = 0;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int n_cmp;
    int n_err;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       img_words[$];

    rv_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .BASE_WORD (BASE_WORD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with mem_we high is one memory write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte at a negedge, leave after its handshake plus gap idle cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_before_byte: got %b want 1 (byte %02h)", in_ready, b);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Streams img_words as an image and checks writes and final status
    task automatic load_image(input string name, input bit do_reset,
                              input logic [7:0] csum_byte, input int gap);
        int          n;
        logic [7:0]  ref_csum;
        logic [7:0]  b;
        logic [31:0] w;
        bit          good;
        n = img_words.size();
        if (do_reset) reset_dut();
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gap);
        ref_csum = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = img_words[i];
            for (int k = 0; k < 4; k++) begin
                b = 8'(w >> (8 * k));
                ref_csum = ref_csum ^ b;
                send_byte(b, gap);
            end
        end
        n_cmp++;
        if (done !== 1'b0 || core_rst !== 1'b1) begin
            n_err++;
            $display("FAIL %s pre_csum: done=%b core_rst=%b want done=0 core_rst=1", name, done, core_rst);
        end
        send_byte(csum_byte, 0);
        good = (csum_byte == ref_csum);
        n_cmp++;
        if (done !== good || error !== !good || core_rst !== !good || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s status: done=%b error=%b core_rst=%b in_ready=%b want %b %b %b 0",
                     name, done, error, core_rst, in_ready, good, !good, !good);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr_q.size() != n) begin
            n_err++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== ADDR_W'(BASE_WORD + i) || wr_data_q[i] !== img_words[i]) begin
                    n_err++;
                    $display("FAIL %s write[%0d]: got (%0h,%08h) want (%0h,%08h)", name, i,
                             wr_addr_q[i], wr_data_q[i], BASE_WORD + i, img_words[i]);
                end
            end
        end
        n_cmp++;
        if (done !== good || error !== !good) begin
            n_err++;
            $display("FAIL %s sticky: done=%b error=%b want %b %b", name, done, error, good, !good);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 ||
            core_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%0h wdata=%08h crst=%b done=%b err=%b want 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: rdy=%b we=%b done=%b err=%b want 1 0 0 0",
                     in_ready, mem_we, done, error);
        end
    endtask

    task automatic test_good_image();
        img_words = '{32'h0000_0013, 32'h0010_0073};
        load_image("good_2word", 1'b1, 8'h70, 0);
    endtask

    task automatic test_zero_length();
        img_words.delete();
        load_image("zero_len", 1'b1, 8'h00, 0);
    endtask

    task automatic test_bad_checksum();
        img_words = '{32'h0000_0013, 32'h0010_0073};
        load_image("bad_csum", 1'b1, 8'h71, 0);
    endtask

    task automatic test_gapped();
        img_words = '{32'h0000_0013, 32'h0010_0073};
        load_image("gapped", 1'b1, 8'h70, 3);
    endtask

    task automatic test_oversize();
        logic [7:0] hdr[4];
        // Exactly MAX_WORDS is still a legal header
        reset_dut();
        hdr = '{8'h00, 8'h40, 8'h00, 8'h00};
        for (int k = 0; k < 4; k++) send_byte(hdr[k], 0);
        n_cmp++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL max_words_hdr: error=%b in_ready=%b want 0 1", error, in_ready);
        end
        reset_dut();
        wr_addr_q.delete();
        wr_data_q.delete();
        hdr = '{8'h01, 8'h40, 8'h00, 8'h00};
        for (int k = 0; k < 4; k++) send_byte(hdr[k], 0);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || core_rst !== 1'b1) begin
            n_err++;
            $display("FAIL oversize_status: error=%b done=%b in_ready=%b core_rst=%b want 1 0 0 1",
                     error, done, in_ready, core_rst);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL oversize_ready[%0d]: got %b want 0", i, in_ready);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (wr_addr_q.size() != 0 || error !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL oversize_after: writes=%0d error=%b done=%b want 0 1 0",
                     wr_addr_q.size(), error, done);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] part[10];
        part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h00};
        reset_dut();
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < 10; k++) send_byte(part[k], 0);
        n_cmp++;
        if (wr_addr_q.size() != 1 || mem_wdata !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL midload_partial: writes=%0d wdata=%08h want 1 00000013", wr_addr_q.size(), mem_wdata);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || core_rst !== 1'b1 || in_ready !== 1'b1 || mem_wdata !== 32'h0 ||
            done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL midload_async_reset: we=%b crst=%b rdy=%b wdata=%08h done=%b err=%b want 0 1 1 0 0 0",
                     mem_we, core_rst, in_ready, mem_wdata, done, error);
        end
        @(negedge clk);
        rst = 1'b0;
        img_words = '{32'hDEAD_BEEF};
        load_image("after_midload", 1'b0, 8'h22, 0);
    endtask

    task automatic test_random();
        int          n;
        int          gap;
        logic [7:0]  cs;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(0, 6));
            gap = int'($urandom_range(0, 2));
            img_words.delete();
            cs = 8'h00;
            for (int i = 0; i < n; i++) begin
                img_words.push_back($urandom);
                for (int k = 0; k < 4; k++) cs = cs ^ 8'(img_words[i] >> (8 * k));
            end
            if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            load_image($sformatf("random%0d", it), 1'b1, cs, gap);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_good_image();
        test_zero_length();
        test_bad_checksum();
        test_oversize();
        test_gapped();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_boot_loader.md
Name: rv_boot_loader

Overview:
Synthesizable program loader that sits directly upstream of the rv core and its memory.
- Accepts a byte stream (valid/ready) carrying a length header, a little-endian word payload and an XOR checksum.
- Writes each assembled word into program memory starting at BASE_WORD.
- Holds the core in reset until the image is fully written and verified.
- Replaces the file-based memory preload for hardware bring-up; the same binary images load identically.

Parameters:
- ADDR_W, 32, width of mem_addr (word address).
- MAX_WORDS, 16384, largest accepted image in words; larger length header means error.
- BASE_WORD, 0, word address of the first payload word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle; transfer when in_valid && in_ready
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  32  write data
- core_rst  out  1  reset to rv core; high until load verified
- done  out  1  sticky: image loaded and checksum good
- error  out  1  sticky: bad length or checksum mismatch

Behaviour:
- Reset values (asynchronous, immediate on rst rise):
  - state=LEN, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rst=1, done=0, error=0.
  - Byte, word and length counters and checksum accumulator = 0.
- Stream format:
  - 4 length bytes: word count N, little-endian.
  - 4*N payload bytes; per word, the first byte goes to bits [7:0] and the fourth to [31:24].
  - 1 checksum byte = XOR of all payload bytes (0x00 when N=0).
- States:
  - LEN: in_ready=1; collect 4 bytes into len. On the 4th handshake:
    - if len > MAX_WORDS, go to ERR;
    - else if len == 0, go to CSUM;
    - else go to DATA.
  - DATA: in_ready=1; each accepted byte XORs into csum and shifts into the word assembler.
    - On the 4th byte of a word, the next cycle drives mem_we=1, mem_addr=BASE_WORD+word_idx, mem_wdata=assembled word, then word_idx++.
    - After word N-1's 4th byte, go to CSUM.
  - CSUM: in_ready=1; on handshake, go to DONE if in_data==csum, else ERR.
  - DONE: in_ready=0, done=1, core_rst=0 from the cycle after the checksum handshake. Terminal until rst.
  - ERR: in_ready=0, error=1, core_rst=1. Terminal until rst.
- Write strobe:
  - mem_we is registered and lasts exactly one cycle per word.
  - The write register is separate from the assembler, so bytes are accepted back-to-back with no stall. in_ready never drops in LEN/DATA/CSUM.
- Ordering: the last mem_we occurs no later than the cycle of the checksum handshake, so every write precedes core_rst deassertion.
- Idle cycles (in_valid=0) in any receiving state: no state, counter or checksum change.
- in_data is ignored when in_valid=0 or in_ready=0.
- mem_addr wraps modulo 2^ADDR_W; no other bound beyond MAX_WORDS.
- rst mid-load: outputs return to reset values at once; the partial image stays in memory; the next stream starts a fresh header.
- done and error are never both 1.

Decomposition:
- Shared package rv_pkg:
  - boot_state_t enum (LEN, DATA, CSUM, DONE, ERR);
  - BOOT_HDR_BYTES=4;
  - BOOT_WORD_BYTES=4.
- One sub-module, rv_byte_packer:
  - byte shift/assemble with 2-bit byte counter, load strobe, clear input;
  - emits word_valid and word[31:0] on the 4th byte.
- The FSM, checksum, length/address counters and write register stay in rv_boot_loader.

Test Plan:
- Good 2-word image: stream 02 00 00 00, 13 00 00 00, 73 00 10 00, 70 back-to-back.
  -> writes (0,0x00000013) then (1,0x00100073), each a one-cycle mem_we.
  -> done=1 and core_rst=0 one cycle after the checksum byte; in_ready=0 thereafter.
- Zero length: stream 00 00 00 00, 00.
  -> no mem_we; done=1; core_rst=0.
- Bad checksum: same 2-word image with final byte 0x71.
  -> both writes occur; error=1; done=0; core_rst stays 1; in_ready=0.
- Oversize: header for MAX_WORDS+1 (MAX_WORDS=16384: 01 40 00 00).
  -> error=1 the cycle after the 4th header byte; no mem_we; further bytes not accepted.
- Gapped stream: good 2-word image with in_valid low for 3 cycles between every byte.
  -> identical writes and checksum result; no spurious mem_we during gaps.
- Reset mid-load: assert rst after 6 payload bytes.
  -> mem_we=0 and core_rst=1 immediately.
  -> then stream a full 1-word image (01 00 00 00, EF BE AD DE, checksum 0x22) -> write (0,0xDEADBEEF), done=1.
